// File: rtl/nlc_horner_sched.sv
// Per-channel normalise + degree-5 Horner sequencer over shared fp units.
// Ports: clk, rst (async active-low), srdyi/srdyo/busy frame control,
// ch_sel/par_sel/par_data/x_fp sources, mul_*/add_* unit handshakes,
// y_fp/y_ch/y_vld result; err only with NLC_TIMEOUT_EN defined.
module nlc_horner_sched #(
  parameter int NUM_CH  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        srdyi,
  output logic        srdyo,
  output logic        busy,
  output logic [3:0]  ch_sel,
  output logic [2:0]  par_sel,
  input  logic [31:0] par_data,
  input  logic [31:0] x_fp,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_srdyi,
  input  logic [31:0] mul_p,
  input  logic        mul_srdyo,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_srdyi,
  input  logic [31:0] add_s,
  input  logic        add_srdyo,
`ifdef NLC_TIMEOUT_EN
  output logic        err,
`endif
  output logic [31:0] y_fp,
  output logic [3:0]  y_ch,
  output logic        y_vld
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    NORM_ADD = 3'd1,
    NORM_MUL = 3'd2,
    H_MUL    = 3'd3,
    H_ADD    = 3'd4
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_CH - 1);

  state_t      state, state_n;
  logic        pend, pend_n;
  logic [2:0]  k, k_n;
  logic [3:0]  ch, ch_n;
  logic [31:0] acc, acc_n;
  logic [31:0] z, z_n;
  logic [31:0] y_fp_n;
  logic [3:0]  y_ch_n;
  logic        y_vld_n;
  logic        busy_n;
  logic        srdyo_n;
  logic        is_add, is_mul;
  logic        got, fin, issue;
`ifdef NLC_TIMEOUT_EN
  logic [15:0] wcnt, wcnt_n;
  logic        err_n;
`endif

  assign is_add = (state == NORM_ADD) || (state == H_ADD);
  assign is_mul = (state == NORM_MUL) || (state == H_MUL);
  assign got    = pend & ((is_add & add_srdyo) |
                          (is_mul & mul_srdyo));
  // last y_vld seen back in IDLE: frame done next cycle
  assign fin    = y_vld & busy & (state == IDLE);
  assign issue  = ~pend & (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pend  <= 1'b0;
      k     <= '0;
      ch    <= '0;
      acc   <= '0;
      z     <= '0;
      y_fp  <= '0;
      y_ch  <= '0;
      y_vld <= 1'b0;
      busy  <= 1'b0;
      srdyo <= 1'b0;
`ifdef NLC_TIMEOUT_EN
      wcnt  <= '0;
      err   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      pend  <= pend_n;
      k     <= k_n;
      ch    <= ch_n;
      acc   <= acc_n;
      z     <= z_n;
      y_fp  <= y_fp_n;
      y_ch  <= y_ch_n;
      y_vld <= y_vld_n;
      busy  <= busy_n;
      srdyo <= srdyo_n;
`ifdef NLC_TIMEOUT_EN
      wcnt  <= wcnt_n;
      err   <= err_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    pend_n  = pend;
    k_n     = k;
    ch_n    = ch;
    acc_n   = acc;
    z_n     = z;
    y_fp_n  = y_fp;
    y_ch_n  = y_ch;
    y_vld_n = 1'b0;
    busy_n  = busy;
    srdyo_n = 1'b0;
`ifdef NLC_TIMEOUT_EN
    wcnt_n  = wcnt;
    err_n   = err;
`endif
    if (fin) begin
      srdyo_n = 1'b1;
      busy_n  = 1'b0;
    end
    unique case (state)
      IDLE: begin
        if (srdyi && !busy) begin
          state_n = NORM_ADD;
          ch_n    = '0;
          k_n     = '0;
          pend_n  = 1'b0;
          busy_n  = 1'b1;
`ifdef NLC_TIMEOUT_EN
          err_n   = 1'b0;
`endif
        end
      end
      default: begin
        if (!pend) begin
          pend_n = 1'b1;
`ifdef NLC_TIMEOUT_EN
          wcnt_n = 16'd1;
`endif
        end else if (got) begin
          pend_n = 1'b0;
          case (state)
            NORM_ADD: begin
              acc_n   = add_s;
              state_n = NORM_MUL;
            end
            NORM_MUL: begin
              z_n     = mul_p;
              k_n     = 3'd4;
              state_n = H_MUL;
            end
            H_MUL: begin
              acc_n   = mul_p;
              state_n = H_ADD;
            end
            H_ADD: begin
              acc_n = add_s;
              if (k != 3'd0) begin
                k_n     = k - 3'd1;
                state_n = H_MUL;
              end else begin
                y_vld_n = 1'b1;
                y_fp_n  = add_s;
                y_ch_n  = ch;
                if (ch == LAST) begin
                  state_n = IDLE;
                end else begin
                  ch_n    = ch + 4'd1;
                  state_n = NORM_ADD;
                end
              end
            end
            default: ;
          endcase
        end
`ifdef NLC_TIMEOUT_EN
        else if (wcnt == 16'(TIMEOUT - 1)) begin
          state_n = IDLE;
          pend_n  = 1'b0;
          busy_n  = 1'b0;
          srdyo_n = 1'b1;
          err_n   = 1'b1;
        end else begin
          wcnt_n = wcnt + 16'd1;
        end
`endif
      end
    endcase
  end

  always_comb begin
    ch_sel    = '0;
    par_sel   = '0;
    mul_a     = '0;
    mul_b     = '0;
    mul_srdyi = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_srdyi = 1'b0;
    unique case (state)
      NORM_ADD: begin
        ch_sel    = ch;
        par_sel   = 3'd6;
        add_a     = x_fp;
        add_b     = par_data;
        add_srdyi = issue;
      end
      NORM_MUL: begin
        ch_sel    = ch;
        par_sel   = 3'd7;
        mul_a     = acc;
        mul_b     = par_data;
        mul_srdyi = issue;
      end
      H_MUL: begin
        // first product uses coeff_5 straight from the source
        ch_sel    = ch;
        par_sel   = (k == 3'd4) ? 3'd5 : k;
        mul_a     = (k == 3'd4) ? par_data : acc;
        mul_b     = z;
        mul_srdyi = issue;
      end
      H_ADD: begin
        ch_sel    = ch;
        par_sel   = k;
        add_a     = acc;
        add_b     = par_data;
        add_srdyi = issue;
      end
      default: ;
    endcase
  end

endmodule
